// File: rtl/regs_xfer_pkg.sv
// Shared types and helpers for the X/Y/S register transfer sequencer.
package regs_xfer_pkg;

    localparam int unsigned FLD_W = 3;
    localparam int unsigned CMD_W = 2 * FLD_W;

    typedef enum logic [FLD_W-1:0] {
        SRC_NONE = 3'd0,
        SRC_X    = 3'd1,
        SRC_Y    = 3'd2,
        SRC_S    = 3'd3,
        SRC_EXT  = 3'd4
    } src_e;

    typedef enum logic [FLD_W-1:0] {
        DST_NONE = 3'd0,
        DST_X    = 3'd1,
        DST_Y    = 3'd2,
        DST_S    = 3'd3,
        DST_ADL  = 3'd4
    } dst_e;

    typedef struct packed {
        src_e src;
        dst_e dst;
    } xfer_cmd_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_LOAD  = 2'd2;

    typedef struct packed {
        logic x_sb;
        logic y_sb;
        logic s_sb;
        logic ext_sb_drv;
        logic s_adl;
        logic sb_x;
        logic sb_y;
        logic sb_s;
    } strobe_t;

    // Reserved codes, self-transfers and ADL targets not sourced from S are NOPs.
    function automatic logic cmd_illegal(input xfer_cmd_t c);
        logic [FLD_W-1:0] s;
        logic [FLD_W-1:0] d;
        s = c.src;
        d = c.dst;
        return (s > 3'd4) || (d > 3'd4) ||
               ((s == d) && (s != 3'd0)) ||
               ((d == 3'd4) && (s != 3'd3));
    endfunction

endpackage

// File: rtl/regs_xfer_arb.sv
// Two-way requester arbiter: fixed B priority or round-robin between A and B.
module regs_xfer_arb
#(
    parameter int unsigned PRIO_B = 0
)
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_gnt_c,
    output logic b_gnt_c
);

    logic ptr_q;
    logic ptr_d;
    logic pick_b;

    // ptr_q = 1 means B is favoured on the next contested grant.
    always_comb begin
        pick_b = 1'b0;
        if (b_valid && !a_valid) begin
            pick_b = 1'b1;
        end else if (a_valid && b_valid) begin
            pick_b = (PRIO_B != 0) ? 1'b1 : ptr_q;
        end
        a_gnt_c = en && a_valid && !pick_b;
        b_gnt_c = en && b_valid && pick_b;
        ptr_d   = ptr_q;
        if (a_gnt_c) begin
            ptr_d = 1'b1;
        end else if (b_gnt_c) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regs_xfer_ctl.sv
// Register-to-bus transfer sequencer for the X/Y/S register file.
// Optional REGS_XFER_BUSCHK_EN adds the sticky err output and an SB contention check.
module regs_xfer_ctl
    import regs_xfer_pkg::*;
#(
    parameter int unsigned PRIO_B      = 0,
    parameter int unsigned LOAD_CYCLES = 1
)
(
    input  logic             PHI2,
    input  logic             RES,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [CMD_W-1:0] a_cmd,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [CMD_W-1:0] b_cmd,
    output logic             Y_SB,
    output logic             SB_Y,
    output logic             X_SB,
    output logic             SB_X,
    output logic             S_SB,
    output logic             S_ADL,
    output logic             S_S,
    output logic             SB_S,
    output logic             ext_sb_drv,
    output logic             busy,
    output logic             done,
`ifdef REGS_XFER_BUSCHK_EN
    output logic             err,
`endif
    output logic             done_id
);

    if ((LOAD_CYCLES < 1) || (LOAD_CYCLES > 4)) begin : g_bad_load_cycles
        $error("regs_xfer_ctl: LOAD_CYCLES must be within 1..4");
    end

    localparam logic [1:0] LOAD_LAST = 2'(LOAD_CYCLES - 1);

    logic       a_gnt;
    logic       b_gnt;
    logic       idle;
    xfer_cmd_t  req_cmd;
    logic       req_illegal;

    state_t     state_q, state_d;
    xfer_cmd_t  cmd_q, cmd_d;
    logic       id_q, id_d;
    logic [1:0] cnt_q, cnt_d;
    strobe_t    stb_q, stb_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       done_id_q, done_id_d;
    logic       s_s_q;

    assign idle = (state_q == ST_IDLE);

    regs_xfer_arb #(.PRIO_B(PRIO_B)) u_arb (
        .clk     (PHI2),
        .rst     (RES),
        .en      (idle),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_gnt_c (a_gnt),
        .b_gnt_c (b_gnt)
    );

    assign a_ready     = a_gnt;
    assign b_ready     = b_gnt;
    assign req_cmd     = b_gnt ? xfer_cmd_t'(b_cmd) : xfer_cmd_t'(a_cmd);
    assign req_illegal = cmd_illegal(req_cmd);

    // Sequencing: illegal commands are captured as NONE->NONE so they run as timed NOPs.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (a_gnt || b_gnt) begin
                    state_d = ST_DRIVE;
                    cmd_d   = req_illegal ? '0 : req_cmd;
                    id_d    = b_gnt;
                end
            end
            ST_DRIVE: begin
                state_d = ST_LOAD;
                cnt_d   = LOAD_LAST;
            end
            ST_LOAD: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the outputs come straight from flops.
    always_comb begin
        stb_d = '0;
        if ((state_d == ST_DRIVE) || (state_d == ST_LOAD)) begin
            case (cmd_d.src)
                SRC_X:   stb_d.x_sb = 1'b1;
                SRC_Y:   stb_d.y_sb = 1'b1;
                SRC_S: begin
                    if (cmd_d.dst == DST_ADL) begin
                        stb_d.s_adl = 1'b1;
                    end else begin
                        stb_d.s_sb = 1'b1;
                    end
                end
                SRC_EXT: stb_d.ext_sb_drv = 1'b1;
                default: ;
            endcase
        end
        if (state_d == ST_LOAD) begin
            case (cmd_d.dst)
                DST_X:   stb_d.sb_x  = 1'b1;
                DST_Y:   stb_d.sb_y  = 1'b1;
                DST_S:   stb_d.sb_s  = 1'b1;
                DST_ADL: stb_d.s_adl = 1'b1;
                default: ;
            endcase
        end
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_LOAD) && (cnt_d == 2'd0);
        done_id_d = done_d & id_d;
    end

    always_ff @(posedge PHI2 or posedge RES) begin
        if (RES) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            id_q      <= 1'b0;
            cnt_q     <= 2'd0;
            stb_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            s_s_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            stb_q     <= stb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            s_s_q     <= ~stb_d.sb_s;
        end
    end

    assign X_SB       = stb_q.x_sb;
    assign Y_SB       = stb_q.y_sb;
    assign S_SB       = stb_q.s_sb;
    assign ext_sb_drv = stb_q.ext_sb_drv;
    assign S_ADL      = stb_q.s_adl;
    assign SB_X       = stb_q.sb_x;
    assign SB_Y       = stb_q.sb_y;
    assign SB_S       = stb_q.sb_s;
    assign S_S        = s_s_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_id    = done_id_q;

`ifdef REGS_XFER_BUSCHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (idle & (a_gnt | b_gnt) & req_illegal);
    end

    always_ff @(posedge PHI2 or posedge RES) begin
        if (RES) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    a_sb_single_source: assert property (@(posedge PHI2) disable iff (RES)
        $onehot0({X_SB, Y_SB, S_SB, ext_sb_drv}))
        else $error("regs_xfer_ctl: more than one SB source driven");
`endif

endmodule

// File: tb/tb_regs_xfer_ctl.sv
// Scoreboard bench for regs_xfer_ctl: u_rr (round-robin, LOAD_CYCLES=1), u_pb (B priority, LOAD_CYCLES=3).
module tb_regs_xfer_ctl;
    import regs_xfer_pkg::*;

    typedef struct {
        int          dut;
        int          id;
        logic [31:0] cnts;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] a_valid, b_valid, a_ready, b_ready;
    logic [1:0] x_sb, y_sb, s_sb, sb_x, sb_y, sb_s, s_adl, s_s, ext, busy, done, done_id;
    logic [5:0] a_cmd [2];
    logic [5:0] b_cmd [2];
`ifdef REGS_XFER_BUSCHK_EN
    logic [1:0] err;
`endif

    exp_t        sbq[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] obs [2];
    int          lat [2];
    bit          armed [2];

    always #5 clk = ~clk;

    regs_xfer_ctl #(.PRIO_B(0), .LOAD_CYCLES(1)) u_rr (
        .PHI2(clk), .RES(rst),
        .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_cmd(a_cmd[0]),
        .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_cmd(b_cmd[0]),
        .Y_SB(y_sb[0]), .SB_Y(sb_y[0]), .X_SB(x_sb[0]), .SB_X(sb_x[0]),
        .S_SB(s_sb[0]), .S_ADL(s_adl[0]), .S_S(s_s[0]), .SB_S(sb_s[0]),
        .ext_sb_drv(ext[0]), .busy(busy[0]), .done(done[0]),
`ifdef REGS_XFER_BUSCHK_EN
        .err(err[0]),
`endif
        .done_id(done_id[0])
    );

    regs_xfer_ctl #(.PRIO_B(1), .LOAD_CYCLES(3)) u_pb (
        .PHI2(clk), .RES(rst),
        .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_cmd(a_cmd[1]),
        .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_cmd(b_cmd[1]),
        .Y_SB(y_sb[1]), .SB_Y(sb_y[1]), .X_SB(x_sb[1]), .SB_X(sb_x[1]),
        .S_SB(s_sb[1]), .S_ADL(s_adl[1]), .S_S(s_s[1]), .SB_S(sb_s[1]),
        .ext_sb_drv(ext[1]), .busy(busy[1]), .done(done[1]),
`ifdef REGS_XFER_BUSCHK_EN
        .err(err[1]),
`endif
        .done_id(done_id[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-strobe cycle counts packed as nibbles: x_sb,y_sb,s_sb,ext,s_adl,sb_x,sb_y,sb_s.
    function automatic logic [31:0] cv(int x, int y, int s, int e, int adl, int sbx, int sby, int sbs);
        return {4'(x), 4'(y), 4'(s), 4'(e), 4'(adl), 4'(sbx), 4'(sby), 4'(sbs)};
    endfunction

    function automatic logic [5:0] mk(input src_e s, input dst_e d);
        return {s, d};
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on each done pulse.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic [7:0]  sv;
            logic [31:0] inc;
            exp_t        e;
            sv = {x_sb[g], y_sb[g], s_sb[g], ext[g], s_adl[g], sb_x[g], sb_y[g], sb_s[g]};
            inc = '0;
            for (int k = 0; k < 8; k++) inc[4*k] = sv[k];
            check("s_s_is_not_sb_s", int'(s_s[g]), int'(!sb_s[g]));
            check("sb_single_source", int'($countones(sv[7:4]) <= 1), 1);
            if (!busy[g]) check("idle_no_strobes", int'(sv), 0);
            if (rst) begin
                obs[g]   = '0;
                armed[g] = 1'b0;
            end else begin
                if (busy[g]) obs[g] = obs[g] + inc;
                if (a_ready[g] || b_ready[g]) begin
                    lat[g]   = 0;
                    armed[g] = 1'b1;
                end else if (armed[g]) begin
                    lat[g]++;
                end
                if (done[g]) begin
                    check("done_expected", int'(sbq.size() > 0), 1);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check("done_dut", g, e.dut);
                        check("done_id", int'(done_id[g]), e.id);
                        check("strobe_counts", int'(obs[g]), int'(e.cnts));
                        check("done_latency", lat[g], e.lat);
                    end
                    obs[g]   = '0;
                    armed[g] = 1'b0;
                end
            end
        end
    end

    task automatic push(input int d, input int id, input logic [31:0] cnts);
        exp_t e;
        e.dut  = d;
        e.id   = id;
        e.cnts = cnts;
        e.lat  = (d == 0) ? 2 : 4;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained", int'(sbq.size()), 0);
    endtask

    task automatic xfer(input int d, input bit side_b, input logic [5:0] cmd, input logic [31:0] cnts);
        int t = 0;
        bit got = 1'b0;
        push(d, int'(side_b), cnts);
        @(posedge clk); #1;
        if (side_b) begin b_valid[d] = 1'b1; b_cmd[d] = cmd; end
        else        begin a_valid[d] = 1'b1; a_cmd[d] = cmd; end
        while (!got && t < 20) begin
            @(negedge clk);
            t++;
            got = side_b ? b_ready[d] : a_ready[d];
        end
        check("accepted", int'(got), 1);
        @(posedge clk); #1;
        a_valid[d] = 1'b0;
        b_valid[d] = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ga, gb, t;
        rst = 1'b1;
        a_valid = '0;
        b_valid = '0;
        for (int i = 0; i < 2; i++) begin
            a_cmd[i] = '0; b_cmd[i] = '0; obs[i] = '0; lat[i] = 0; armed[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_busy", int'(busy[i]), 0);
            check("reset_done", int'(done[i]), 0);
            check("reset_done_id", int'(done_id[i]), 0);
            check("reset_s_s", int'(s_s[i]), 1);
            check("reset_ready", int'({a_ready[i], b_ready[i]}), 0);
`ifdef REGS_XFER_BUSCHK_EN
            check("reset_err", int'(err[i]), 0);
`endif
        end
        @(posedge clk); #1;
        rst = 1'b0;

        xfer(0, 1'b0, mk(SRC_X, DST_Y),   cv(2, 0, 0, 0, 0, 0, 1, 0));
        xfer(0, 1'b1, mk(SRC_S, DST_ADL), cv(0, 0, 0, 0, 2, 0, 0, 0));

        // Contested round-robin: last grant was B, so A leads.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) push(0, 0, cv(0, 2, 0, 0, 0, 1, 0, 0));
            else            push(0, 1, cv(0, 0, 2, 0, 0, 0, 1, 0));
        end
        @(posedge clk); #1;
        a_cmd[0] = mk(SRC_Y, DST_X);
        b_cmd[0] = mk(SRC_S, DST_Y);
        a_valid[0] = 1'b1;
        b_valid[0] = 1'b1;
        ga = 0; t = 0;
        while (ga < 5 && t < 200) begin
            @(negedge clk);
            t++;
            if (a_ready[0] || b_ready[0]) ga++;
        end
        check("rr_grant_count", ga, 5);
        @(posedge clk); #1;
        a_valid[0] = 1'b0;
        b_valid[0] = 1'b0;
        drain();

        xfer(0, 1'b0, mk(SRC_X, DST_X), cv(0, 0, 0, 0, 0, 0, 0, 0));
`ifdef REGS_XFER_BUSCHK_EN
        check("err_after_first_illegal", int'(err[0]), 1);
`endif
        xfer(0, 1'b0, mk(SRC_Y, DST_ADL), cv(0, 0, 0, 0, 0, 0, 0, 0));
        xfer(0, 1'b0, 6'b110_001,        cv(0, 0, 0, 0, 0, 0, 0, 0));
`ifdef REGS_XFER_BUSCHK_EN
        check("err_sticky", int'(err[0]), 1);
        check("err_other_inst", int'(err[1]), 0);
`endif

        xfer(1, 1'b0, mk(SRC_EXT, DST_S), cv(0, 0, 0, 4, 0, 0, 0, 3));

        // Fixed B priority: three B grants while A waits, then A.
        for (int i = 0; i < 3; i++) push(1, 1, cv(4, 0, 0, 0, 0, 0, 3, 0));
        push(1, 0, cv(0, 4, 0, 0, 0, 0, 0, 3));
        @(posedge clk); #1;
        a_cmd[1] = mk(SRC_Y, DST_S);
        b_cmd[1] = mk(SRC_X, DST_Y);
        a_valid[1] = 1'b1;
        b_valid[1] = 1'b1;
        ga = 0; gb = 0; t = 0;
        while (gb < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (b_ready[1]) gb++;
            if (a_ready[1]) ga++;
        end
        @(posedge clk); #1;
        b_valid[1] = 1'b0;
        while (ga < 1 && t < 200) begin
            @(negedge clk);
            t++;
            if (a_ready[1]) ga++;
        end
        check("pb_b_grants", gb, 3);
        check("pb_a_grants", ga, 1);
        @(posedge clk); #1;
        a_valid[1] = 1'b0;
        drain();

        // Abort a {Y,X} transfer in its first LOAD cycle; no done may follow.
        @(posedge clk); #1;
        a_cmd[1] = mk(SRC_Y, DST_X);
        a_valid[1] = 1'b1;
        t = 0;
        while (!a_ready[1] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("abort_cmd_accepted", int'(a_ready[1]), 1);
        @(posedge clk); #1;
        a_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("pre_abort_sb_x", int'(sb_x[1]), 1);
        #1 rst = 1'b1;
        #1;
        check("abort_strobes", int'({x_sb[1], y_sb[1], s_sb[1], ext[1], s_adl[1], sb_x[1], sb_y[1], sb_s[1]}), 0);
        check("abort_s_s", int'(s_s[1]), 1);
        check("abort_busy", int'(busy[1]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_abort_busy", int'(busy[1]), 0);
        check("post_abort_no_done", int'(done[1]), 0);
`ifdef REGS_XFER_BUSCHK_EN
        check("post_abort_err_cleared", int'(err[0]), 0);
`endif
        xfer(1, 1'b0, mk(SRC_X, DST_S), cv(4, 0, 0, 0, 0, 0, 0, 3));

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
